// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked sequential ALU: opcode encodings,
// controller state type and status-flag bit positions.
package alu_pkg;

  // Legacy encodings
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  // Extended encodings
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Bit positions inside the packed status-flag vector
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ERR   = 4;
  localparam int NFLG      = 5;

endpackage

// File: rtl/alu_seq_if.sv
// Operand-fetch / write-back handshake bundle around the ALU.
// slave = the ALU's view, master = the driver/consumer view.
interface alu_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero;
  logic         out_neg;
  logic         out_carry;
  logic         out_ovf;
  logic         out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data,
    output out_zero, out_neg, out_carry, out_ovf, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_zero, out_neg, out_carry, out_ovf, out_err
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, N steps.
// o_done pulses during the final step; o_prod is valid in that same cycle
// (it is the accumulator value the final step would write).
module alu_mul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_done,
  output logic [N-1:0] o_prod
);
  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplier;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = (r_cnt == CW'(1));
  assign o_prod    = w_acc_nxt;

  // ---- step counter (control, reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(N);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // ---- operand shift registers and accumulator (data, no reset) ----
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked N-bit ALU. Single-cycle ops are evaluated combinationally and
// land in the output register at the accept edge; MUL hands off to the
// iterative multiplier and the block stays busy until it completes.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]    data;
    logic [NFLG-1:0] flg;
  } res_t;

  function automatic logic [NFLG-1:0] mk_flags(input logic [N-1:0] r,
                                               input logic c, input logic v,
                                               input logic e);
    logic [NFLG-1:0] f;
    f            = '0;
    f[FLG_ZERO]  = (r == '0);
    f[FLG_NEG]   = r[N-1];
    f[FLG_CARRY] = c;
    f[FLG_OVF]   = v;
    f[FLG_ERR]   = e;
    return f;
  endfunction

  // Carry on SUB is not-borrow; overflow compares result sign to A's sign
  // when the operands' effective signs agree.
  function automatic res_t alu_eval(input logic [3:0] op,
                                    input logic [N-1:0] a,
                                    input logic [N-1:0] b);
    logic [N:0]          sum;
    logic [N:0]          dif;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic [SHW-1:0]      sh;
    logic [N-1:0]        r;
    logic                c;
    logic                v;
    logic                e;
    res_t                res;
    sa  = $signed(a);
    sb  = $signed(b);
    sh  = b[SHW-1:0];
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    e   = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD: begin
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        r = dif[N-1:0];
        c = ~dif[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SLTU: r = {{(N-1){1'b0}}, (a < b)};
      OP_SLT:  r = {{(N-1){1'b0}}, (sa < sb)};
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = sa >>> sh;
      OP_MUL:  r = '0;
      default: e = 1'b1;
    endcase
    res.data = r;
    res.flg  = mk_flags(r, c, v, e);
    return res;
  endfunction

  state_t          r_state;
  logic            r_vld_p1;
  logic [N-1:0]    r_data_p1;
  logic [NFLG-1:0] r_flg_p1;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_start;
  logic            w_done;
  logic            w_mul_done;
  logic [N-1:0]    w_prod;
  res_t            w_res;

  assign w_in_ready = (r_state == ST_IDLE) && (!r_vld_p1 || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.in_op == OP_MUL);
  assign w_start    = w_accept && w_is_mul;
  assign w_mul_done = (r_state == ST_MUL) && w_done;
  assign w_res      = alu_eval(bus.in_op, bus.in_a, bus.in_b);

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );

  // ---- controller: IDLE accepts, MUL waits for the multiplier ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start)    r_state <= ST_MUL;
        ST_MUL:  if (w_mul_done) r_state <= ST_IDLE;
        default:                 r_state <= ST_IDLE;
      endcase
    end
  end

  // ---- output stage p1: load on accept or MUL completion, hold while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_flg_p1  <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_res.data;
      r_flg_p1  <= w_res.flg;
    end else if (w_mul_done) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_prod;
      r_flg_p1  <= mk_flags(w_prod, 1'b0, 1'b0, 1'b0);
    end else if (bus.out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_data  = r_data_p1;
  assign bus.out_zero  = r_flg_p1[FLG_ZERO];
  assign bus.out_neg   = r_flg_p1[FLG_NEG];
  assign bus.out_carry = r_flg_p1[FLG_CARRY];
  assign bus.out_ovf   = r_flg_p1[FLG_OVF];
  assign bus.out_err   = r_flg_p1[FLG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes hand-computed results at
// accept time, a negedge monitor pops and compares on every delivered result.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] data;
    logic [4:0]   flg;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   pushes = 0;

  // flag vector order: {err, ovf, carry, neg, zero}
  wire [4:0] w_flg = {bus.out_err, bus.out_ovf, bus.out_carry, bus.out_neg, bus.out_zero};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is delivered when valid and ready are both high at the edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h, expected no output", bus.out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        pops++;
        chk({e.name, "_data"}, 64'(bus.out_data), 64'(e.data));
        chk({e.name, "_flags"}, 64'(w_flg), 64'(e.flg));
      end
    end
  end

  // Drive an op and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] ed, input logic [4:0] ef,
                       input bit push);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!got && n < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        if (push) begin
          sbq.push_back('{name: nm, data: ed, flg: ef});
          pushes++;
        end
      end
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 for 100 cycles, expected acceptance", nm);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Single-cycle op: result must be valid right after the accept edge.
  task automatic op1(input string nm, input logic [3:0] op, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [N-1:0] ed, input logic [4:0] ef);
    issue(nm, op, a, b, ed, ef, 1'b1);
    chk({nm, "_latency"}, 64'(bus.out_valid), 64'(1));
  endtask

  // MUL: busy with no output for N-1 edges after accept, valid after edge N.
  task automatic mul(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] ed, input logic [4:0] ef);
    bit ok;
    issue(nm, OP_MUL, a, b, ed, ef, 1'b1);
    ok = !bus.in_ready && !bus.out_valid;
    for (int i = 0; i < N - 1; i++) begin
      @(posedge clk);
      #1;
      if (bus.in_ready || bus.out_valid) ok = 1'b0;
    end
    chk({nm, "_busy"}, 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    chk({nm, "_latency"}, 64'(bus.out_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'h0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_out_data", 64'(bus.out_data), 64'(0));
    chk("reset_flags", 64'(w_flg), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));

    // ADD boundaries
    op1("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00101);
    op1("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01010);
    // SUB / compare
    op1("sub_neg", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 5'b00010);
    op1("sub_pos", OP_SUB, 32'd7, 32'd5, 32'h2, 5'b00100);
    op1("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00001);
    op1("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
    // logic
    op1("or", OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 5'b00000);
    op1("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'b00010);
    // shifts
    op1("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 5'b00010);
    op1("sll_wrapamt", OP_SLL, 32'h1, 32'h21, 32'h2, 5'b00000);
    op1("srl_by0", OP_SRL, 32'h8000_0000, 32'h20, 32'h8000_0000, 5'b00010);
    op1("srl4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 5'b00000);
    // illegal opcodes
    op1("illegal_f", 4'b1111, 32'h1234, 32'h5678, 32'h0, 5'b10001);
    op1("illegal_4", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b10001);

    // MUL
    mul("mul_ffff", 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 5'b00010);
    mul("mul_zero", 32'h8000_0000, 32'h2, 32'h0, 5'b00001);
    mul("mul_small", 32'd3, 32'd5, 32'd15, 5'b00000);

    // Backpressure: first AND stalls downstream for 3 cycles
    op1("and1", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00010);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_AND;
    bus.in_a      = 32'h1234_5678;
    bus.in_b      = 32'h0000_FFFF;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.in_ready || bus.out_data !== 32'hF000_F000 || w_flg !== 5'b00010)
        ok = 1'b0;
    end
    chk("stall_hold", 64'(ok), 64'(1));
    bus.out_ready = 1'b1;
    issue("and2", OP_AND, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 5'b00000, 1'b1);
    issue("and3", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 5'b00001, 1'b1);
    issue("and4", OP_AND, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 5'b00010, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_before_reset", 64'(sbq.size()), 64'(0));

    // Reset in the middle of a MUL: nothing may come out
    issue("mul_reset", OP_MUL, 32'd3, 32'd5, 32'd15, 5'b00000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid_data", 64'(bus.out_data), 64'(0));
    chk("rst_mid_flags", 64'(w_flg), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_output", 64'(bus.out_valid), 64'(0));

    // Still functional after the reset
    op1("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    chk("delivered_count", 64'(pops), 64'(pushes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
